alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one alu instance (32-bit A/B, 4-bit opcode, result, zero) between two requesters.
//   Requester ports use valid/ready handshakes; arbitration is round-robin.
//   Operands are registered, the ALU runs for one cycle, and result/zero are registered.
//   The response is held on a shared bus until the owning requester accepts it.
//   Sits between the decode/issue stages and the alu datapath.
// PARAMETERS
//   WIDTH  32  operand/result width; must match alu
//   OPW    4   opcode width; must match alu
//   CNTW   16  width of completed-operation counter
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   req0_valid   in   1      requester 0 has an operation
//   req0_ready   out  1      arbiter accepts requester 0 this cycle
//   req0_a       in   WIDTH  requester 0 operand A
//   req0_b       in   WIDTH  requester 0 operand B
//   req0_op      in   OPW    requester 0 ALU opcode
//   req1_valid   in   1      requester 1 has an operation
//   req1_ready   out  1      arbiter accepts requester 1 this cycle
//   req1_a       in   WIDTH  requester 1 operand A
//   req1_b       in   WIDTH  requester 1 operand B
//   req1_op      in   OPW    requester 1 ALU opcode
//   resp0_valid  out  1      response for requester 0 is on the shared bus
//   resp1_valid  out  1      response for requester 1 is on the shared bus
//   resp0_ready  in   1      requester 0 takes its response
//   resp1_ready  in   1      requester 1 takes its response
//   resp_result  out  WIDTH  registered ALU result
//   resp_zero    out  1      registered ALU zero flag
//   busy         out  1      high when state != IDLE
//   done_count   out  CNTW   number of completed responses
// BEHAVIOUR
//   Reset values:
//     - state=IDLE, rr_ptr=0 (requester 0 preferred), owner=0.
//     - All ready/valid outputs 0.
//     - resp_result=0, resp_zero=0, done_count=0.
//     - Reset mid-operation discards the in-flight op; no response is issued.
//   FSM:
//     - IDLE: grant is combinational from the valids.
//         - Only one valid: grant that requester.
//         - Both valid: grant rr_ptr.
//         - The granted reqN_ready=1; the other ready=0; none if no valid.
//         - On handshake: latch a/b/op into internal regs, owner<=granted,
//           rr_ptr<=~granted, go to EXEC.
//     - EXEC (1 cycle): alu is driven only from the latched regs.
//         - At the edge: resp_result<=result, resp_zero<=zero, go to RESP.
//         - Both readys are 0.
//     - RESP: resp{owner}_valid=1; the other resp valid=0; both readys 0.
//         - On resp{owner}_ready: done_count+=1 (wraps mod 2^CNTW), go to IDLE.
//         - Non-owner resp_ready is ignored.
//   Timing:
//     - Accept at edge t; resp_valid high from cycle t+2.
//     - Earliest next accept is the cycle after the response handshake (minimum 3 cycles/op).
//   Invariants:
//     - resp_result/resp_zero stay stable while resp valid is high and until the next EXEC edge.
//     - Requester operand inputs are don't-care after accept; the latched copies are used.
//     - The pointer advances only on a grant.
//     - A lone requester is served back-to-back regardless of rr_ptr.
// TESTING
//   1. Reset for 2 cycles -> all outputs 0, busy=0; then req0 ADD 5+7 -> resp0_valid at t+2,
//      resp_result=12, zero=0, done_count=1.
//   2. Both valid at the same cycle after reset -> req0 granted first, then req1;
//      a third simultaneous pair grants req0 again (alternating).
//   3. req1 SUB 9-9, resp1_ready held low 5 cycles -> resp1_valid high for 5 cycles,
//      result=0 and zero=1 stable throughout; req0 ready stays 0.
//   4. Change req0_a/b right after accept -> response uses the accepted values.
//   5. Assert reset during EXEC and during RESP -> IDLE next cycle, resp valids 0,
//      done_count=0, rr_ptr=0.
//   6. Preload done_count to 2^CNTW-1 (or use CNTW=2) and complete an op -> count wraps to 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Operands and results are registered; the response is held until its owner accepts it.

module alu #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int SHW = $clog2(WIDTH);

    // Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu
    always_comb begin
        result = '0;
        case (op)
            OPW'(0): result = a + b;
            OPW'(1): result = a - b;
            OPW'(2): result = a & b;
            OPW'(3): result = a | b;
            OPW'(4): result = a ^ b;
            OPW'(5): result = a << b[SHW-1:0];
            OPW'(6): result = a >> b[SHW-1:0];
            OPW'(7): result = $signed(a) >>> b[SHW-1:0];
            OPW'(8): result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OPW'(9): result = {{(WIDTH-1){1'b0}}, a < b};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// state | meaning
// IDLE  | waiting for a request; grant is combinational from the valids
// EXEC  | ALU evaluates the latched operands; result registered at the edge
// RESP  | response held on the shared bus until the owner takes it
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             busy,
    output logic [CNTW-1:0]  done_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             rr_ptr, owner;
    logic             grant, grant_valid, accept, resp_fire;
    logic [WIDTH-1:0] a_q, b_q, alu_result;
    logic [OPW-1:0]   op_q;
    logic             alu_zero;

    alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // rr_ptr only breaks ties; a lone requester always wins
    assign grant_valid = req0_valid | req1_valid;
    assign grant       = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    assign accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign resp_fire   = owner ? (resp1_valid && resp1_ready) : (resp0_valid && resp0_ready);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && grant_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp0_valid = ~owner;
                resp1_valid = owner;
                if (owner ? resp1_ready : resp0_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            done_count  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q    <= grant ? req1_a  : req0_a;
                b_q    <= grant ? req1_b  : req0_b;
                op_q   <= grant ? req1_op : req0_op;
                owner  <= grant;
                rr_ptr <= ~grant;
            end
            if (state == EXEC) begin
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
            end
            if (resp_fire)
                done_count <= done_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a transaction-level model.
// A second instance with a 2-bit counter shares all stimulus to exercise count wrap.

module tb_alu_arbiter;
    localparam int W = 32;
    localparam int OPW = 4;
    localparam int CNTW = 16;

    logic clk = 1'b0;
    logic reset;
    logic req0_valid, req1_valid, resp0_ready, resp1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0] req0_op, req1_op;

    logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp_zero, busy;
    logic [W-1:0] resp_result;
    logic [CNTW-1:0] done_count;

    logic req0_ready_w, req1_ready_w, resp0_valid_w, resp1_valid_w, resp_zero_w, busy_w;
    logic [W-1:0] resp_result_w;
    logic [1:0] done_count_w;

    int tests = 0;
    int fails = 0;

    logic prefer;          // requester that wins a tie
    int unsigned count;    // completed responses since reset

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .busy(busy), .done_count(done_count)
    );

    alu_arbiter #(.WIDTH(W), .OPW(OPW), .CNTW(2)) dut_w (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready_w),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready_w),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid_w), .resp1_valid(resp1_valid_w),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_result(resp_result_w), .resp_zero(resp_zero_w),
        .busy(busy_w), .done_count(done_count_w)
    );

    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return 32'($signed(a) >>> sh);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a negedge. Drives one arbitration round, checks the grant,
    // the EXEC cycle, the held response for `hold` cycles, and the completion.
    task automatic run_op(input logic v0, input logic v1,
                          input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                          input int hold, input string tag);
        logic g;
        logic [31:0] exp_r;
        logic exp_z;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        g = (v0 && v1) ? prefer : v1;
        exp_r = g ? model_alu(a1, b1, op1) : model_alu(a0, b0, op0);
        exp_z = (exp_r == 32'd0);
        #1;
        check({tag, ".grant0"}, 64'(req0_ready), 64'(!g));
        check({tag, ".grant1"}, 64'(req1_ready), 64'(g));
        check({tag, ".idle_busy"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        prefer = ~g;
        // Accepted requester scrambles its operands; the other one starts asking.
        if (g) begin
            req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom);
            req0_valid = 1'b1;
        end else begin
            req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom);
            req1_valid = 1'b1;
        end
        @(negedge clk);
        check({tag, ".exec_busy"}, 64'(busy), 64'd1);
        check({tag, ".exec_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
        check({tag, ".exec_rvalid"}, 64'({resp0_valid, resp1_valid}), 64'd0);
        @(negedge clk);
        // Non-owner's resp_ready is raised to show it is ignored.
        if (g) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) begin
                if (g) resp1_ready = 1'b1; else resp0_ready = 1'b1;
                #1;
            end
            check({tag, ".rvalid"}, 64'({resp1_valid, resp0_valid}), g ? 64'd2 : 64'd1);
            check({tag, ".result"}, 64'(resp_result), 64'(exp_r));
            check({tag, ".zero"}, 64'(resp_zero), 64'(exp_z));
            check({tag, ".resp_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
            if (i < hold) @(negedge clk);
        end
        @(posedge clk);
        #1;
        count++;
        check({tag, ".count"}, 64'(done_count), 64'(count % 65536));
        check({tag, ".count_wrap"}, 64'(done_count_w), 64'(count % 4));
        check({tag, ".done_busy"}, 64'(busy), 64'd0);
        check({tag, ".done_rvalid"}, 64'({resp0_valid, resp1_valid}), 64'd0);
        check({tag, ".hold_result"}, 64'(resp_result), 64'(exp_r));
        @(negedge clk);
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    // Accepts a lone req0 op then resets during EXEC (in_resp=0) or RESP (in_resp=1).
    task automatic abort_op(input logic in_resp, input string tag);
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 32'd3; req0_b = 32'd4; req0_op = 4'd0;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        if (in_resp) @(posedge clk);
        @(negedge clk);
        if (in_resp) check({tag, ".pre_rvalid"}, 64'(resp0_valid), 64'd1);
        else check({tag, ".pre_busy"}, 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".rvalid"}, 64'({resp0_valid, resp1_valid}), 64'd0);
        check({tag, ".count"}, 64'(done_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        count = 0;
        prefer = 1'b0;
        check({tag, ".post_count"}, 64'(done_count), 64'd0);
    endtask

    logic rv0, rv1;

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        prefer = 1'b0;
        count = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 64'({req0_ready, req1_ready}), 64'd0);
        check("rst.rvalid", 64'({resp0_valid, resp1_valid}), 64'd0);
        check("rst.result", 64'(resp_result), 64'd0);
        check("rst.zero", 64'(resp_zero), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.count", 64'(done_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(1, 0, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 4'd0, 0, "add5_7");

        run_op(1, 1, 32'd10, 32'd3, 4'd1, 32'd6, 32'd6, 4'd2, 0, "pair1");
        run_op(1, 1, 32'd1, 32'd2, 4'd3, 32'hF0F0, 32'h0FF0, 4'd4, 1, "pair2");
        run_op(1, 1, 32'd7, 32'd2, 4'd5, 32'd8, 32'd1, 4'd6, 0, "pair3");

        run_op(0, 1, 32'd0, 32'd0, 4'd0, 32'd9, 32'd9, 4'd1, 5, "sub9_9");

        run_op(1, 0, 32'd11, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 0, "lone0_a");
        run_op(1, 0, 32'h8000_0000, 32'd4, 4'd7, 32'd0, 32'd0, 4'd0, 0, "lone0_b");

        abort_op(1'b0, "rst_exec");
        run_op(1, 1, 32'd1, 32'd1, 4'd1, 32'd2, 32'd3, 4'd0, 0, "rr_after_exec");
        abort_op(1'b1, "rst_resp");
        run_op(1, 1, 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd5, 32'd5, 4'd9, 0, "rr_after_resp");

        for (int n = 0; n < 40; n++) begin
            rv0 = 1'($urandom);
            rv1 = 1'($urandom);
            if (!rv0 && !rv1) rv0 = 1'b1;
            run_op(rv0, rv1,
                   $urandom, (n % 5 == 0) ? 32'd0 : $urandom, 4'($urandom_range(0, 11)),
                   $urandom, $urandom_range(0, 40), 4'($urandom_range(0, 11)),
                   int'($urandom_range(0, 3)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
